vga_anim_sequencer: RTL

Frame-level controller for the VGA pattern datapath. It turns vsync into a per-frame tick and advances the animation counter that the pattern logic adds to and subtracts from pixel terms. It also schedules pattern modes with automatic dwell and fade-out/fade-in transitions, and applies user next/pause requests on frame boundaries only. It sits between hvsync_generator and the colour mapping in the top-level tt_um wrapper.

---
 rtl/vga_anim_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_anim_sequencer.sv
// vga_anim_sequencer
// Frame-level controller for the VGA pattern datapath. It converts vsync into a
// one-clock frame tick and advances the animation phase counter on each tick.
// It also schedules pattern modes, with an automatic dwell period and a
// fade-out / fade-in transition around each mode change. User next/pause
// requests are latched and then applied only on frame boundaries.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   vsync        vsync from hvsync_generator; a frame starts on its rising edge
//   btn_next     next-mode request; the rising edge counts
//   btn_pause    pause toggle request; the rising edge counts
//   auto_en      1 = switch mode automatically after DWELL_FRAMES frames
//   speed        animation step select; step = speed + 1
//   frame_tick   one-clock pulse per frame
//   anim_counter animation phase, wraps modulo 1024
//   mode         active pattern index
//   fade_level   brightness, 3 = full, 0 = black
//   paused       high while paused
//   fading       high during fade-out, mode switch and fade-in
module vga_anim_sequencer #(
  parameter int NUM_MODES    = 4,
  parameter int DWELL_FRAMES = 600,
  parameter int FADE_FRAMES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       btn_next,
  input  logic       btn_pause,
  input  logic       auto_en,
  input  logic [2:0] speed,
  output logic       frame_tick,
  output logic [9:0] anim_counter,
  output logic [1:0] mode,
  output logic [1:0] fade_level,
  output logic       paused,
  output logic       fading
);

  localparam logic [9:0] DWELL_LAST = 10'(DWELL_FRAMES - 1);
  localparam logic [3:0] FADE_LAST  = 4'(FADE_FRAMES - 1);
  localparam logic [1:0] MODE_LAST  = 2'(NUM_MODES - 1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_PAUSED,
    ST_FADE_OUT,
    ST_SWITCH,
    ST_FADE_IN
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] dwell, dwell_nxt;
  logic [3:0] fade_cnt, fade_cnt_nxt;
  logic [1:0] fade_nxt;
  logic [1:0] mode_nxt;
  logic [9:0] anim_nxt;
  logic       next_pend, next_pend_nxt;
  logic       pause_pend, pause_pend_nxt;
  logic       vs_q, next_q, pause_q;
  logic       next_rise, pause_rise;

  assign next_rise  = btn_next & ~next_q;
  assign pause_rise = btn_pause & ~pause_q;

  function automatic logic [1:0] mode_inc(input logic [1:0] m);
    return (m == MODE_LAST) ? 2'd0 : m + 2'd1;
  endfunction

  // NOTE: every variable gets its hold value first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    dwell_nxt      = dwell;
    fade_cnt_nxt   = fade_cnt;
    fade_nxt       = fade_level;
    mode_nxt       = mode;
    anim_nxt       = anim_counter;
    next_pend_nxt  = next_pend;
    pause_pend_nxt = pause_pend;

    if (frame_tick && state != ST_PAUSED)
      anim_nxt = anim_counter + {7'd0, speed} + 10'd1;

    case (state)
      ST_RUN: begin
        if (frame_tick) begin
          // Pause wins over next; the next request stays latched.
          if (pause_pend) begin
            state_nxt      = ST_PAUSED;
            pause_pend_nxt = 1'b0;
          end else if (next_pend) begin
            state_nxt     = ST_FADE_OUT;
            next_pend_nxt = 1'b0;
            dwell_nxt     = '0;
            fade_cnt_nxt  = '0;
          end else if (auto_en && dwell == DWELL_LAST) begin
            state_nxt    = ST_FADE_OUT;
            dwell_nxt    = '0;
            fade_cnt_nxt = '0;
          end else if (dwell != DWELL_LAST) begin
            dwell_nxt = dwell + 10'd1;
          end
        end
      end
      ST_PAUSED: begin
        if (frame_tick) begin
          if (pause_pend) begin
            state_nxt      = ST_RUN;
            pause_pend_nxt = 1'b0;
          end else if (next_pend) begin
            // Mode steps immediately while paused; no fade.
            mode_nxt      = mode_inc(mode);
            next_pend_nxt = 1'b0;
          end
        end
      end
      ST_FADE_OUT: begin
        if (frame_tick) begin
          next_pend_nxt = 1'b0;
          if (fade_cnt == FADE_LAST) begin
            fade_cnt_nxt = '0;
            fade_nxt     = fade_level - 2'd1;
            if (fade_level == 2'd1) state_nxt = ST_SWITCH;
          end else begin
            fade_cnt_nxt = fade_cnt + 4'd1;
          end
        end
      end
      ST_SWITCH: begin
        // Single clock, not gated by frame_tick.
        mode_nxt     = mode_inc(mode);
        fade_cnt_nxt = '0;
        state_nxt    = ST_FADE_IN;
        if (frame_tick) next_pend_nxt = 1'b0;
      end
      ST_FADE_IN: begin
        if (frame_tick) begin
          next_pend_nxt = 1'b0;
          if (fade_cnt == FADE_LAST) begin
            fade_cnt_nxt = '0;
            fade_nxt     = fade_level + 2'd1;
            if (fade_level == 2'd2) begin
              state_nxt = ST_RUN;
              dwell_nxt = '0;
            end
          end else begin
            fade_cnt_nxt = fade_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    // A fresh button edge is never lost, even on the edge that consumes the
    // previous request.
    if (next_rise)  next_pend_nxt  = 1'b1;
    if (pause_rise) pause_pend_nxt = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      dwell        <= '0;
      fade_cnt     <= '0;
      fade_level   <= 2'd3;
      mode         <= '0;
      anim_counter <= '0;
      next_pend    <= 1'b0;
      pause_pend   <= 1'b0;
      vs_q         <= 1'b0;
      next_q       <= 1'b0;
      pause_q      <= 1'b0;
      frame_tick   <= 1'b0;
      paused       <= 1'b0;
      fading       <= 1'b0;
    end else begin
      vs_q         <= vsync;
      next_q       <= btn_next;
      pause_q      <= btn_pause;
      frame_tick   <= vsync & ~vs_q;
      state        <= state_nxt;
      dwell        <= dwell_nxt;
      fade_cnt     <= fade_cnt_nxt;
      fade_level   <= fade_nxt;
      mode         <= mode_nxt;
      anim_counter <= anim_nxt;
      next_pend    <= next_pend_nxt;
      pause_pend   <= pause_pend_nxt;
      paused       <= (state_nxt == ST_PAUSED);
      fading       <= (state_nxt == ST_FADE_OUT) || (state_nxt == ST_SWITCH) ||
                      (state_nxt == ST_FADE_IN);
    end
  end

endmodule
